wbmstr_arbiter: RTL and testbench
=================================

# wbmstr_arbiter

Two-master Wishbone (pipelined) arbiter with bus-timeout watchdog, placed directly downstream of the DMA controller's master port. It merges the CPU master (port A) and the DMA master (port B) onto one system bus. It holds ownership for a whole bus cycle and routes acks, errors and read data back to the owner only. It converts a stuck bus cycle into a Wishbone error so neither master can hang.

## Interface
Parameters:
- `AW`, 30, word-address width
- `DW`, 32, data width
- `FIXED_PRI`, 1: 1 = A always wins ties; 0 = round-robin, loser of the last grant wins ties
- `LGTO`, 10, timeout counter width; timeout fires after `2^LGTO-1` stalled cycles

Ports (clock and reset first):
- `i_clk` in 1: the single clock
- `i_rst_n` in 1: reset, synchronous and active-low
- `i_a_cyc`, `i_a_stb`, `i_a_we` in 1 each: master A request
- `i_a_addr` in AW, `i_a_data` in DW: master A address and write data
- `o_a_ack`, `o_a_stall`, `o_a_err` out 1 each: master A responses
- `o_a_data` out DW: master A read data
- `i_b_*` / `o_b_*`: identical set for master B (DMA)
- `o_cyc`, `o_stb`, `o_we` out 1 each: slave-side request
- `o_addr` out AW, `o_data` out DW: slave-side address and write data
- `i_ack`, `i_stall`, `i_err` in 1 each: slave-side responses
- `i_data` in DW: slave-side read data
- `o_timeout` out 1: one-cycle pulse on watchdog expiry, for the interrupt controller

## Operation
- Four states: IDLE, OWN_A, OWN_B, DRAIN. `owner` and `state` are registered.
- IDLE:
  - `i_a_cyc` only → OWN_A.
  - `i_b_cyc` only → OWN_B.
  - Both asserted: `FIXED_PRI=1` → OWN_A. `FIXED_PRI=0` → the master not granted last time; `last` resets to B, so A wins the first tie.
- OWN_x:
  - `o_cyc = i_x_cyc`; `o_stb = i_x_stb`; `o_we/o_addr/o_data` come from x.
  - `o_x_stall = i_stall`; `o_x_ack = i_ack`; `o_x_err = i_err`; `o_x_data = i_data`.
  - `i_x_cyc` low → IDLE. No re-grant in the same cycle.
- Non-owner (and both masters in IDLE):
  - `o_y_stall = i_y_stb`.
  - `o_y_ack = o_y_err = 0`.
  - `o_y_data` is driven from `i_data` but is meaningless.
- Slave `i_err` in OWN_x: forwarded to x. The state stays OWN_x until x drops cyc; masters must drop cyc on error.
- Watchdog:
  - `tocount` (LGTO bits) clears in IDLE/DRAIN, on any `i_ack`/`i_err`, and on any accepted strobe (`o_stb && !i_stall`).
  - Otherwise, in OWN_x with `o_cyc` high, it increments. It saturates at its top value and never wraps.
  - At `tocount == 2^LGTO-2` with no clearing event: the next cycle asserts `o_x_err`=1 and `o_timeout`=1 for one cycle, and state → DRAIN.
- DRAIN:
  - `o_cyc = o_stb = 0`; the former owner sees `stall` = its stb.
  - Late slave acks/errs are discarded.
  - Exit to IDLE when the former owner's cyc is low.
- Simultaneous events:
  - `i_err` on the expiry cycle: slave error wins. It is forwarded once, there is no second err, `o_timeout` stays 0, and the state stays OWN_x.
  - Owner dropping cyc on the expiry cycle: → IDLE, no timeout.
- Reset (`!i_rst_n` at a clock edge), including mid-cycle:
  - state = IDLE, `last` = B, `tocount` = 0, `o_timeout` = 0.
  - All combinational outputs then follow IDLE: `o_cyc = o_stb = 0`, both acks/errs 0.

## Timing
- Grant latency: one clock. A master raising cyc+stb in cycle n sees `o_cyc`/`o_stb` at cycle n+1. It is stalled during n.
- Registered: `state`, `owner`, `last`, `tocount`, `o_timeout`, and the timeout-generated err bit.
- Combinational from inputs: all other outputs (pure muxes on `owner`).
- Release latency: owner drops cyc at n, state is IDLE at n+1, a waiting master is granted at n+2.
- Timeout: err appears exactly `2^LGTO-1` cycles after the last progress event while owned.

## Structure
- Shared package: state encoding constants (`ARB_IDLE=2'b00`, `ARB_OWN_A=2'b01`, `ARB_OWN_B=2'b10`, `ARB_DRAIN=2'b11`).
- One natural sub-module, `wb_watchdog`: counter, clear/enable inputs and expiry pulse. Everything else is flat muxing in the top.

## Test plan
- A alone: one read to 0x100 with slave acking data 0xDEADBEEF after 3 cycles → `o_cyc` one clock after request; `o_a_ack` with `o_a_data=0xDEADBEEF`; `o_b_*` silent.
- Tie, `FIXED_PRI=0`: A and B both raise cyc in the same cycle, three times in a row → grants A, B, A. With `FIXED_PRI=1` → A, A, A.
- B owns with 4 pipelined writes while A requests → A stalled throughout. A is granted exactly 2 clocks after B drops cyc. No A strobe leaks to the slave.
- `LGTO=4`, B issues stb with slave stalling forever → `o_b_err` and `o_timeout` pulse at cycle 15 after the last progress. `o_cyc` low next cycle. A late slave ack in DRAIN is not seen by B.
- Slave `i_err` on the same cycle as watchdog expiry → single `o_a_err`, `o_timeout`=0.
- `i_rst_n`=0 mid-transfer while B owns → next cycle `o_cyc`=0 and state IDLE. A then wins a tie in round-robin mode.

Source files
------------

// File: rtl/wbmstr_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// Holds the arbiter state encoding and the owner identifiers used by the
// top level when steering requests and responses.
package wbmstr_arbiter_pkg;

  // Arbiter state encoding
  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_OWN_A = 2'b01;
  localparam logic [1:0] ARB_OWN_B = 2'b10;
  localparam logic [1:0] ARB_DRAIN = 2'b11;

  // Owner / last-grant identifiers
  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog for the Wishbone arbiter.
// Counts stalled cycles of an owned bus cycle and flags expiry once the
// counter would reach its top value.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clear        : progress event or not-owned state; zeroes the counter
//   i_enable       : bus cycle owned and active; lets the counter advance
//   o_expire       : combinational, expiry happens at the coming edge
//   o_timeout      : registered one-cycle expiry pulse
module wb_watchdog
  import wbmstr_arbiter_pkg::*;
#(
  parameter int LGTO = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire,
  output logic o_timeout
);

  localparam logic [LGTO-1:0] TO_ONE  = {{(LGTO-1){1'b0}}, 1'b1};
  localparam logic [LGTO-1:0] TO_TOP  = {LGTO{1'b1}};
  localparam logic [LGTO-1:0] TO_LAST = TO_TOP - TO_ONE;

  logic [LGTO-1:0] tocount_r;
  logic            timeout_r;

  // Expiry only when the cycle is still live and nothing made progress;
  // a simultaneous slave err/ack or a dropped cyc suppresses it.
  assign o_expire  = i_enable && !i_clear && (tocount_r == TO_LAST);
  assign o_timeout = timeout_r;

  // Stall counter (saturating) and registered expiry pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tocount_r <= {LGTO{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= o_expire;
      if (i_clear) begin
        tocount_r <= {LGTO{1'b0}};
      end else if (i_enable && (tocount_r != TO_TOP)) begin
        tocount_r <= tocount_r + TO_ONE;
      end else begin
        tocount_r <= tocount_r;
      end
    end
  end

endmodule

// File: rtl/wbmstr_arbiter.sv
// Two-master pipelined Wishbone arbiter with bus-timeout watchdog.
// Master A (CPU) and master B (DMA) share one slave-side bus. Ownership
// lasts a whole bus cycle; responses go to the owner only. A stalled cycle
// is turned into an error to the owner and the bus is drained.
// Ports:
//   i_clk, i_rst_n              : clock, synchronous active-low reset
//   i_a_* / o_a_*               : master A request / responses
//   i_b_* / o_b_*               : master B request / responses
//   o_cyc,o_stb,o_we,o_addr,o_data : slave-side request
//   i_ack,i_stall,i_err,i_data  : slave-side responses
//   o_timeout                   : one-cycle watchdog expiry pulse
module wbmstr_arbiter
  import wbmstr_arbiter_pkg::*;
#(
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter bit FIXED_PRI = 1'b1,
  parameter int LGTO      = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_cyc,
  input  logic          i_a_stb,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_data,
  output logic          o_a_ack,
  output logic          o_a_stall,
  output logic          o_a_err,
  output logic [DW-1:0] o_a_data,
  input  logic          i_b_cyc,
  input  logic          i_b_stb,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_data,
  output logic          o_b_ack,
  output logic          o_b_stall,
  output logic          o_b_err,
  output logic [DW-1:0] o_b_data,
  output logic          o_cyc,
  output logic          o_stb,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_ack,
  input  logic          i_stall,
  input  logic          i_err,
  input  logic [DW-1:0] i_data,
  output logic          o_timeout
);

  logic [1:0] state_r;
  logic       owner_r;
  logic       last_r;
  logic       owned_s;
  logic       owner_cyc_s;
  logic       a_wins_s;
  logic       wd_clear_s;
  logic       wd_enable_s;
  logic       wd_expire_s;
  logic       wd_timeout_s;

  assign owned_s     = (state_r == ARB_OWN_A) || (state_r == ARB_OWN_B);
  assign owner_cyc_s = (owner_r == OWNER_B) ? i_b_cyc : i_a_cyc;
  // In round-robin mode A wins a tie only if B was granted last
  assign a_wins_s    = !i_b_cyc || FIXED_PRI || (last_r == OWNER_B);

  // Read data is a plain broadcast; only the owner gets an ack with it
  assign o_a_data = i_data;
  assign o_b_data = i_data;

  // Progress (ack, err, accepted strobe) or not owning the bus resets the
  // watchdog; only a live owned cycle lets it count.
  assign wd_clear_s  = !owned_s || i_ack || i_err || (o_stb && !i_stall);
  assign wd_enable_s = owned_s && o_cyc;

  wb_watchdog #(
    .LGTO (LGTO)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (wd_clear_s),
    .i_enable  (wd_enable_s),
    .o_expire  (wd_expire_s),
    .o_timeout (wd_timeout_s)
  );

  assign o_timeout = wd_timeout_s;

  // Grant/ownership state machine with last-grant tracking
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ARB_IDLE;
      owner_r <= OWNER_A;
      last_r  <= OWNER_B;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (i_a_cyc && a_wins_s) begin
            state_r <= ARB_OWN_A;
            owner_r <= OWNER_A;
            last_r  <= OWNER_A;
          end else if (i_b_cyc) begin
            state_r <= ARB_OWN_B;
            owner_r <= OWNER_B;
            last_r  <= OWNER_B;
          end else begin
            state_r <= ARB_IDLE;
          end
        end
        ARB_OWN_A, ARB_OWN_B: begin
          // Dropping cyc beats expiry; expiry already requires o_cyc high
          if (!owner_cyc_s) begin
            state_r <= ARB_IDLE;
          end else if (wd_expire_s) begin
            state_r <= ARB_DRAIN;
          end else begin
            state_r <= state_r;
          end
        end
        ARB_DRAIN: begin
          if (!owner_cyc_s) begin
            state_r <= ARB_IDLE;
          end else begin
            state_r <= ARB_DRAIN;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Request/response steering on the current state and owner
  always_comb begin
    o_cyc     = 1'b0;
    o_stb     = 1'b0;
    o_we      = 1'b0;
    o_addr    = {AW{1'b0}};
    o_data    = {DW{1'b0}};
    o_a_stall = i_a_stb;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_stall = i_b_stb;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    case (state_r)
      ARB_OWN_A: begin
        o_cyc     = i_a_cyc;
        o_stb     = i_a_stb;
        o_we      = i_a_we;
        o_addr    = i_a_addr;
        o_data    = i_a_data;
        o_a_stall = i_stall;
        o_a_ack   = i_ack;
        o_a_err   = i_err;
      end
      ARB_OWN_B: begin
        o_cyc     = i_b_cyc;
        o_stb     = i_b_stb;
        o_we      = i_b_we;
        o_addr    = i_b_addr;
        o_data    = i_b_data;
        o_b_stall = i_stall;
        o_b_ack   = i_ack;
        o_b_err   = i_err;
      end
      ARB_DRAIN: begin
        // Slave responses are dropped; only the timeout err reaches the
        // former owner, on the first drain cycle.
        o_a_err = wd_timeout_s && (owner_r == OWNER_A);
        o_b_err = wd_timeout_s && (owner_r == OWNER_B);
      end
      default: begin
        o_cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wbmstr_arbiter.sv
// Directed testbench for wbmstr_arbiter. Two instances share master and
// slave stimulus: dut (round-robin) and dut_f (fixed priority), both with
// a 4-bit watchdog. Inputs change 1 time unit after the rising edge and
// outputs are checked at the falling edge.
module tb_wbmstr_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_cyc, a_stb, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdat;
  logic          b_cyc, b_stb, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdat;
  logic          ack, stall, err;
  logic [DW-1:0] sdat;

  logic          a_ack, a_stall, a_err, b_ack, b_stall, b_err;
  logic [DW-1:0] a_rdat, b_rdat;
  logic          cyc, stb, we, timeout;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdat;

  logic          f_a_ack, f_a_stall, f_a_err, f_b_ack, f_b_stall, f_b_err;
  logic [DW-1:0] f_a_rdat, f_b_rdat;
  logic          f_cyc, f_stb, f_we, f_timeout;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wbmstr_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1'b0), .LGTO(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_wdat),
    .o_a_ack(a_ack), .o_a_stall(a_stall), .o_a_err(a_err), .o_a_data(a_rdat),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_wdat),
    .o_b_ack(b_ack), .o_b_stall(b_stall), .o_b_err(b_err), .o_b_data(b_rdat),
    .o_cyc(cyc), .o_stb(stb), .o_we(we), .o_addr(addr), .o_data(wdat),
    .i_ack(ack), .i_stall(stall), .i_err(err), .i_data(sdat),
    .o_timeout(timeout)
  );

  wbmstr_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1'b1), .LGTO(4)) dut_f (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_wdat),
    .o_a_ack(f_a_ack), .o_a_stall(f_a_stall), .o_a_err(f_a_err), .o_a_data(f_a_rdat),
    .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_wdat),
    .o_b_ack(f_b_ack), .o_b_stall(f_b_stall), .o_b_err(f_b_err), .o_b_data(f_b_rdat),
    .o_cyc(f_cyc), .o_stb(f_stb), .o_we(f_we), .o_addr(f_addr), .o_data(f_wdat),
    .i_ack(ack), .i_stall(stall), .i_err(err), .i_data(sdat),
    .o_timeout(f_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
    ack = 1'b0; stall = 1'b0; err = 1'b0;
  endtask

  initial begin
    logic [31:0] rr_exp [3];
    rr_exp[0] = 32'h0000_000A;
    rr_exp[1] = 32'h0000_000B;
    rr_exp[2] = 32'h0000_000A;

    rst_n = 1'b0;
    idle_all();
    a_addr = '0; a_wdat = '0; b_addr = '0; b_wdat = '0; sdat = '0;

    // Reset state
    tick(); tick(); mid();
    chk1("rst_cyc", cyc, 1'b0);
    chk1("rst_stb", stb, 1'b0);
    chk1("rst_a_ack", a_ack, 1'b0);
    chk1("rst_b_ack", b_ack, 1'b0);
    chk1("rst_a_err", a_err, 1'b0);
    chk1("rst_b_err", b_err, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    tick(); rst_n = 1'b1; mid();
    chk1("rst_rel_cyc", cyc, 1'b0);

    // Three simultaneous ties: round-robin A,B,A; fixed A,A,A
    for (int r = 0; r < 3; r++) begin
      tick();
      a_cyc = 1'b1; a_stb = 1'b1; a_addr = 30'h00A;
      b_cyc = 1'b1; b_stb = 1'b1; b_addr = 30'h00B;
      mid();
      chk1("tie_req_cyc", cyc, 1'b0);
      tick(); mid();
      chk1("tie_cyc", cyc, 1'b1);
      chkw("tie_rr_grant", {2'b00, addr}, rr_exp[r]);
      chkw("tie_fixed_grant", {2'b00, f_addr}, 32'h0000_000A);
      chk1("tie_loser_stall", (rr_exp[r] == 32'h0000_000A) ? b_stall : a_stall, 1'b1);
      tick(); idle_all(); mid();
      tick(); mid();
    end

    // A alone: read 0x100, slave acks 3 cycles after acceptance
    tick(); a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_addr = 30'h100; mid();
    chk1("a_req_cyc", cyc, 1'b0);
    chk1("a_req_stall", a_stall, 1'b1);
    tick(); mid();
    chk1("a_grant_cyc", cyc, 1'b1);
    chk1("a_grant_stb", stb, 1'b1);
    chkw("a_grant_addr", {2'b00, addr}, 32'h0000_0100);
    chk1("a_grant_stall", a_stall, 1'b0);
    tick(); a_stb = 1'b0; mid();
    tick(); mid();
    chk1("a_noack_yet", a_ack, 1'b0);
    tick(); ack = 1'b1; sdat = 32'hDEAD_BEEF; mid();
    chk1("a_ack", a_ack, 1'b1);
    chkw("a_rdata", a_rdat, 32'hDEAD_BEEF);
    chk1("a_b_ack_quiet", b_ack, 1'b0);
    chk1("a_b_err_quiet", b_err, 1'b0);
    chk1("a_b_stall_quiet", b_stall, 1'b0);
    tick(); ack = 1'b0; a_cyc = 1'b0; mid();
    chk1("a_drop_cyc", cyc, 1'b0);
    tick(); mid();

    // B owns with 4 pipelined writes while A waits
    tick(); b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_addr = 30'h020; b_wdat = 32'h0000_1000; mid();
    tick(); a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b0; a_addr = 30'h300; mid();
    chkw("b_wr_addr0", {2'b00, addr}, 32'h0000_0020);
    chk1("b_wr_we", we, 1'b1);
    chk1("b_wr_a_stall0", a_stall, 1'b1);
    for (int k = 1; k < 4; k++) begin
      tick(); b_addr = 30'h020 + 30'(k); b_wdat = 32'h0000_1000 + 32'(k); ack = 1'b1; mid();
      chkw("b_wr_addr", {2'b00, addr}, 32'h0000_0020 + 32'(k));
      chkw("b_wr_data", wdat, 32'h0000_1000 + 32'(k));
      chk1("b_wr_a_stall", a_stall, 1'b1);
      chk1("b_wr_a_ack", a_ack, 1'b0);
      chk1("b_wr_b_ack", b_ack, 1'b1);
    end
    tick(); b_stb = 1'b0; mid();
    chk1("b_last_ack", b_ack, 1'b1);
    chk1("b_last_stb", stb, 1'b0);
    chk1("b_last_a_stall", a_stall, 1'b1);
    tick(); ack = 1'b0; b_cyc = 1'b0; mid();
    chk1("b_drop_cyc", cyc, 1'b0);
    chk1("b_drop_a_stall", a_stall, 1'b1);
    tick(); mid();
    chk1("rel_idle_cyc", cyc, 1'b0);
    chk1("rel_idle_a_stall", a_stall, 1'b1);
    tick(); mid();
    chk1("rel_a_cyc", cyc, 1'b1);
    chkw("rel_a_addr", {2'b00, addr}, 32'h0000_0300);
    chk1("rel_a_stall", a_stall, 1'b0);
    tick(); a_stb = 1'b0; ack = 1'b1; sdat = 32'h1234_5678; mid();
    chk1("rel_a_ack", a_ack, 1'b1);
    tick(); ack = 1'b0; a_cyc = 1'b0; mid();
    tick(); mid();

    // Watchdog: B strobes, slave stalls forever
    tick(); b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_addr = 30'h040; stall = 1'b1; mid();
    for (int k = 0; k < 15; k++) begin
      tick(); mid();
      chk1("wd_pre_cyc", cyc, 1'b1);
      chk1("wd_pre_err", b_err, 1'b0);
      chk1("wd_pre_timeout", timeout, 1'b0);
    end
    tick(); mid();
    chk1("wd_b_err", b_err, 1'b1);
    chk1("wd_timeout", timeout, 1'b1);
    chk1("wd_a_err", a_err, 1'b0);
    chk1("wd_drain_cyc", cyc, 1'b0);
    chk1("wd_drain_stall", b_stall, 1'b1);
    tick(); ack = 1'b1; mid();
    chk1("wd_late_ack", b_ack, 1'b0);
    chk1("wd_err_once", b_err, 1'b0);
    chk1("wd_timeout_once", timeout, 1'b0);
    chk1("wd_drain_cyc2", cyc, 1'b0);
    tick(); idle_all(); mid();
    tick(); mid();
    chk1("wd_exit_stall", b_stall, 1'b0);
    chk1("wd_exit_cyc", cyc, 1'b0);

    // Slave err on the watchdog expiry cycle
    tick(); a_cyc = 1'b1; a_stb = 1'b1; a_addr = 30'h050; stall = 1'b1; mid();
    for (int k = 0; k < 14; k++) begin
      tick(); mid();
    end
    tick(); err = 1'b1; mid();
    chk1("se_a_err", a_err, 1'b1);
    chk1("se_timeout0", timeout, 1'b0);
    tick(); err = 1'b0; mid();
    chk1("se_no_second_err", a_err, 1'b0);
    chk1("se_timeout1", timeout, 1'b0);
    chk1("se_still_owned", cyc, 1'b1);
    tick(); idle_all(); mid();
    tick(); mid();

    // Reset while B owns, then a tie goes to A
    tick(); b_cyc = 1'b1; b_stb = 1'b1; b_addr = 30'h060; mid();
    tick(); mid();
    chk1("mr_b_cyc", cyc, 1'b1);
    chkw("mr_b_addr", {2'b00, addr}, 32'h0000_0060);
    tick(); rst_n = 1'b0; mid();
    tick(); rst_n = 1'b1; a_cyc = 1'b1; a_stb = 1'b1; a_addr = 30'h070; mid();
    chk1("mr_idle_cyc", cyc, 1'b0);
    chk1("mr_idle_b_stall", b_stall, 1'b1);
    chk1("mr_timeout", timeout, 1'b0);
    tick(); mid();
    chk1("mr_tie_cyc", cyc, 1'b1);
    chkw("mr_tie_addr", {2'b00, addr}, 32'h0000_0070);
    chk1("mr_tie_b_stall", b_stall, 1'b1);
    tick(); idle_all(); mid();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
